// File: rtl/fft_seq_ctrl.sv
// FFT block sequencer.
// Accepts one block of 2**ldn source samples, tags them with block/stage sync pulses
// for the FFT pipeline, then counts 2**ldn result samples and pulses done_o.
//
// Ports:
//   clk_sys        system clock, rising edge
//   rst_sys_n      asynchronous active-low reset
//   start_i        one-cycle block request, ldn_i sampled with it
//   ldn_i          log2 block size
//   src_val_i      source sample available
//   src_rdy_o      controller accepts a source sample (FEED only)
//   block_sync_o   marks sample 0 of the block
//   stage_sync_o   marks samples 0, N/4, N/2, 3N/4
//   data_val_o     accepted sample valid to pipeline
//   ldn_rg_o       latched block size, held until next valid start
//   res_val_i      result sample valid from pipeline
//   busy_o         block in progress
//   done_o         pulse after last result sample
//   err_o          pulse after a start with illegal ldn_i
module fft_seq_ctrl #(
  parameter int unsigned LDN_MIN = 2,
  parameter int unsigned LDN_MAX = 11
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  input  logic       start_i,
  input  logic [3:0] ldn_i,
  input  logic       src_val_i,
  output logic       src_rdy_o,
  output logic       block_sync_o,
  output logic       stage_sync_o,
  output logic       data_val_o,
  output logic [3:0] ldn_rg_o,
  input  logic       res_val_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ldn_q, ldn_d;
  logic [10:0] in_cnt_q, in_cnt_d;
  logic [10:0] out_cnt_q, out_cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        ldn_legal;
  logic [11:0] n_full;
  logic [10:0] n_m1;
  logic [10:0] quarter_mask;
  logic        accept;

  assign ldn_legal    = (32'(ldn_i) >= LDN_MIN) && (32'(ldn_i) <= LDN_MAX);
  assign n_full       = 12'd1 << ldn_q;
  assign n_m1         = 11'(n_full - 12'd1);
  // (N-1)>>2 == N/4-1; zero for N=4, so every sample is a stage boundary.
  assign quarter_mask = n_m1 >> 2;
  assign accept       = (state_q == StFeed) && src_val_i;

  // State register
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= StIdle;
      ldn_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ldn_q     <= ldn_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ldn_d     = ldn_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (ldn_legal) begin
            ldn_d     = ldn_i;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = StFeed;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFeed: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 11'd1;
          if (in_cnt_q == n_m1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (res_val_i) begin
          out_cnt_d = out_cnt_q + 11'd1;
          if (out_cnt_q == n_m1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    src_rdy_o    = (state_q == StFeed);
    data_val_o   = accept;
    block_sync_o = accept && (in_cnt_q == '0);
    stage_sync_o = accept && ((in_cnt_q & quarter_mask) == '0);
    busy_o       = (state_q != StIdle);
    ldn_rg_o     = ldn_q;
    done_o       = done_q;
    err_o        = err_q;
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
module tb_fft_seq_ctrl;

  logic       clk_sys = 1'b0;
  logic       rst_sys_n = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] ldn_i = '0;
  logic       src_val_i = 1'b0;
  logic       res_val_i = 1'b0;
  logic       src_rdy_o, block_sync_o, stage_sync_o, data_val_o;
  logic [3:0] ldn_rg_o;
  logic       busy_o, done_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int last_ldn = 0;

  fft_seq_ctrl dut (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .start_i     (start_i),
    .ldn_i       (ldn_i),
    .src_val_i   (src_val_i),
    .src_rdy_o   (src_rdy_o),
    .block_sync_o(block_sync_o),
    .stage_sync_o(stage_sync_o),
    .data_val_o  (data_val_o),
    .ldn_rg_o    (ldn_rg_o),
    .res_val_i   (res_val_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_outs();
    check_eq("rst_src_rdy", 32'(src_rdy_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_ldn_rg", 32'(ldn_rg_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_err", 32'(err_o), 0);
    check_eq("rst_data_val", 32'(data_val_o), 0);
  endtask

  // One block: expected sync positions come from index arithmetic on the accepted count.
  task automatic run_block(input int ldn, input int pct, input bit do_start, input bit inj,
                           input int rst_at, input int next_ldn);
    int  n = 1 << ldn;
    int  q = n / 4;
    int  cnt = 0;
    int  rc = 0;
    bit  injd = 1'b0;
    if (do_start) begin
      @(negedge clk_sys);
      start_i = 1'b1; ldn_i = 4'(ldn); src_val_i = 1'b0; res_val_i = 1'b0;
      #1 check_eq("pre_start_busy", 32'(busy_o), 0);
      @(posedge clk_sys);
    end
    for (int cyc = 0; cyc < 64 * n + 100 && cnt < n; cyc++) begin
      @(negedge clk_sys);
      start_i   = 1'b0;
      src_val_i = ($urandom_range(99) < 32'(pct));
      res_val_i = 1'($urandom_range(1));
      if (inj && !injd && cnt == n / 2) begin
        start_i = 1'b1; ldn_i = 4'd3; injd = 1'b1;
      end
      #1;
      if (rst_at >= 0 && cnt == rst_at && src_val_i) begin
        rst_sys_n = 1'b0;
        #1 check_reset_outs();
        check_eq("rst_block_sync", 32'(block_sync_o), 0);
        check_eq("rst_stage_sync", 32'(stage_sync_o), 0);
        start_i = 1'b0; src_val_i = 1'b0; res_val_i = 1'b0;
        last_ldn = 0;
        return;
      end
      check_eq("feed_src_rdy", 32'(src_rdy_o), 1);
      check_eq("feed_busy", 32'(busy_o), 1);
      check_eq("feed_err", 32'(err_o), 0);
      check_eq("feed_done", 32'(done_o), 0);
      check_eq("feed_ldn_rg", 32'(ldn_rg_o), 32'(ldn));
      check_eq("feed_data_val", 32'(data_val_o), 32'(src_val_i));
      if (src_val_i) begin
        check_eq("block_sync", 32'(block_sync_o), 32'(cnt == 0));
        check_eq("stage_sync", 32'(stage_sync_o), 32'((cnt % q) == 0));
        cnt++;
      end else begin
        check_eq("gap_block_sync", 32'(block_sync_o), 0);
        check_eq("gap_stage_sync", 32'(stage_sync_o), 0);
      end
    end
    check_eq("feed_count", 32'(cnt), 32'(n));
    for (int cyc = 0; cyc < 64 * n + 100 && rc < n; cyc++) begin
      @(negedge clk_sys);
      start_i   = 1'($urandom_range(1));
      ldn_i     = 4'($urandom_range(15));
      res_val_i = ($urandom_range(99) < 60);
      src_val_i = 1'($urandom_range(1));
      #1;
      check_eq("drain_src_rdy", 32'(src_rdy_o), 0);
      check_eq("drain_data_val", 32'(data_val_o), 0);
      check_eq("drain_block_sync", 32'(block_sync_o), 0);
      check_eq("drain_stage_sync", 32'(stage_sync_o), 0);
      check_eq("drain_busy", 32'(busy_o), 1);
      check_eq("drain_done", 32'(done_o), 0);
      check_eq("drain_err", 32'(err_o), 0);
      if (res_val_i) rc++;
    end
    check_eq("drain_count", 32'(rc), 32'(n));
    @(negedge clk_sys);
    res_val_i = 1'b0; src_val_i = 1'b0; start_i = 1'b0;
    if (next_ldn != 0) begin
      start_i = 1'b1; ldn_i = 4'(next_ldn);
    end
    #1;
    check_eq("done_pulse", 32'(done_o), 1);
    check_eq("done_busy", 32'(busy_o), 0);
    check_eq("done_ldn_rg", 32'(ldn_rg_o), 32'(ldn));
    last_ldn = ldn;
    @(posedge clk_sys);
    if (next_ldn == 0) begin
      @(negedge clk_sys);
      start_i = 1'b0; res_val_i = 1'b1;
      #1;
      check_eq("post_done", 32'(done_o), 0);
      check_eq("post_busy", 32'(busy_o), 0);
      check_eq("post_src_rdy", 32'(src_rdy_o), 0);
      res_val_i = 1'b0;
    end
  endtask

  task automatic bad_start(input int ldn);
    @(negedge clk_sys);
    start_i = 1'b1; ldn_i = 4'(ldn); src_val_i = 1'b1;
    @(negedge clk_sys);
    start_i = 1'b0;
    #1;
    check_eq("err_pulse", 32'(err_o), 1);
    check_eq("err_busy", 32'(busy_o), 0);
    check_eq("err_data_val", 32'(data_val_o), 0);
    check_eq("err_ldn_rg", 32'(ldn_rg_o), 32'(last_ldn));
    @(negedge clk_sys);
    #1;
    check_eq("err_clear", 32'(err_o), 0);
    check_eq("err_busy2", 32'(busy_o), 0);
    src_val_i = 1'b0;
  endtask

  initial begin
    #1 check_reset_outs();
    repeat (3) @(posedge clk_sys);
    #2 rst_sys_n = 1'b1;
    // First start lands on the first rising edge after release.
    run_block(4, 100, 1'b1, 1'b0, -1, 0);
    run_block(6, 50, 1'b1, 1'b0, -1, 0);
    bad_start(1);
    bad_start(12);
    bad_start(0);
    bad_start(15);
    run_block(5, 80, 1'b1, 1'b1, -1, 0);
    run_block(5, 100, 1'b1, 1'b0, 5, 0);
    repeat (2) @(posedge clk_sys);
    #2 rst_sys_n = 1'b1;
    // Abandoned block must not complete after release.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      res_val_i = 1'b1;
      #1;
      check_eq("abandon_done", 32'(done_o), 0);
      check_eq("abandon_busy", 32'(busy_o), 0);
    end
    res_val_i = 1'b0;
    run_block(2, 100, 1'b1, 1'b0, -1, 0);
    run_block(3, 70, 1'b1, 1'b0, -1, 7);
    run_block(7, 60, 1'b0, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) begin
      run_block(int'($urandom_range(2, 8)), int'($urandom_range(30, 100)), 1'b1, 1'b0, -1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
